// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier sequencer:
// FSM state encoding, default operand/counter widths, ALU op encoding.
package booth_pkg;

   localparam int N_DEF     = 16;  // operand width and iteration count
   localparam int CNT_W_DEF = 5;   // iteration counter width, 2**CNT_W > N

   // addsub encoding seen by the datapath adder/subtractor
   localparam logic ALU_ADD = 1'b1;
   localparam logic ALU_SUB = 1'b0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CHECK = 3'd2,
      ADD   = 3'd3,
      SUB   = 3'd4,
      SHIFT = 3'd5,
      DONE  = 3'd6
   } state_e;

endpackage

// File: rtl/booth_ctrl_wdog.sv
// Watchdog for booth_ctrl: counts SHIFT cycles since the last LOAD and
// flags when the count has gone past N without the iteration counter
// reporting zero. Only instantiated when BOOTH_CTRL_WDOG_EN is defined.
module booth_ctrl_wdog
   import booth_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,      // LOAD cycle: restart the count
   input  logic shift_i,    // SHIFT cycle: one more iteration consumed
   output logic expired_o   // more than N shifts since LOAD
);

   // One spare bit so N+1 is representable for any legal N/CNT_W pair.
   localparam int WD_W = CNT_W + 1;

   logic [WD_W-1:0] cnt_q, cnt_d;

   assign expired_o = (cnt_q > WD_W'(N));

   // Next count: clear on LOAD, otherwise count shifts and saturate once expired.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (shift_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/booth_ctrl.sv
// Sequencing FSM for the radix-2 Booth multiplier datapath. Loads the
// operand registers and iteration counter, then steps CHECK / ADD|SUB /
// SHIFT until the counter reports zero, and pulses done.
// All outputs are Moore-decoded from the state register.
// Optional feature: define BOOTH_CTRL_WDOG_EN to add a shift-count
// watchdog that forces DONE with err=1 if the counter never reaches zero.
module booth_ctrl
   import booth_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic start_i,
   input  logic q0_i,
   input  logic qm1_i,
   input  logic eqz_i,
   output logic ld_a_o,
   output logic clr_a_o,
   output logic sft_a_o,
   output logic ld_q_o,
   output logic sft_q_o,
   output logic ld_m_o,
   output logic clr_ff_o,
   output logic addsub_o,
   output logic ld_cnt_o,
   output logic de_cnt_o,
   output logic busy_o,
   output logic done_o,
   output logic err_o
);

   // Reject a counter too narrow to hold the iteration count.
   if (2**CNT_W <= N) begin : g_bad_cfg
      $error("booth_ctrl: 2**CNT_W must exceed N");
   end

   state_e state_q, state_d;
   logic   wdog_expired;

`ifdef BOOTH_CTRL_WDOG_EN
   logic err_q, err_d;

   booth_ctrl_wdog #(
      .N     (N),
      .CNT_W (CNT_W)
   ) u_wdog (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (state_q == LOAD),
      .shift_i   (state_q == SHIFT),
      .expired_o (wdog_expired)
   );

   // err is only meaningful alongside done.
   assign err_o = err_q && (state_q == DONE);

   // Remember that DONE was entered through the watchdog rather than eqz.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`else
   assign wdog_expired = 1'b0;
   assign err_o        = 1'b0;
`endif

   // State register; reset lands in IDLE so every output decodes to 0.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge value regardless of block evaluation order.
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and Moore output decode.
   always_comb begin
      // NOTE: every signal gets a default first so no path through the
      // case statement leaves one unassigned and infers a latch.
      state_d  = state_q;
      ld_a_o   = 1'b0;
      clr_a_o  = 1'b0;
      sft_a_o  = 1'b0;
      ld_q_o   = 1'b0;
      sft_q_o  = 1'b0;
      ld_m_o   = 1'b0;
      clr_ff_o = 1'b0;
      addsub_o = ALU_SUB;
      ld_cnt_o = 1'b0;
      de_cnt_o = 1'b0;
      busy_o   = 1'b0;
      done_o   = 1'b0;
`ifdef BOOTH_CTRL_WDOG_EN
      err_d    = 1'b0;
`endif

      unique case (state_q)
         IDLE: begin
            if (start_i) state_d = LOAD;
         end
         LOAD: begin
            busy_o   = 1'b1;
            ld_m_o   = 1'b1;
            ld_q_o   = 1'b1;
            clr_a_o  = 1'b1;
            clr_ff_o = 1'b1;
            ld_cnt_o = 1'b1;
            state_d  = CHECK;
         end
         CHECK: begin
            busy_o = 1'b1;
            // Counter exhaustion wins over the bit pair.
            if (eqz_i) begin
               state_d = DONE;
            end else if (wdog_expired) begin
               state_d = DONE;
`ifdef BOOTH_CTRL_WDOG_EN
               err_d   = 1'b1;
`endif
            end else begin
               unique case ({q0_i, qm1_i})
                  2'b10:   state_d = SUB;
                  2'b01:   state_d = ADD;
                  default: state_d = SHIFT;
               endcase
            end
         end
         ADD: begin
            busy_o   = 1'b1;
            ld_a_o   = 1'b1;
            addsub_o = ALU_ADD;
            state_d  = SHIFT;
         end
         SUB: begin
            busy_o   = 1'b1;
            ld_a_o   = 1'b1;
            addsub_o = ALU_SUB;
            state_d  = SHIFT;
         end
         SHIFT: begin
            busy_o   = 1'b1;
            sft_a_o  = 1'b1;
            sft_q_o  = 1'b1;
            de_cnt_o = 1'b1;
            state_d  = CHECK;
         end
         DONE: begin
            // start is deliberately not looked at here; it is not queued.
            busy_o  = 1'b1;
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_booth_ctrl.sv
// Self-checking bench for booth_ctrl. A small behavioural Booth datapath
// (A, Q, M, Q(-1), iteration counter) is driven by the DUT strobes and
// feeds q0/qm1/eqz back, so products can be checked against hand values.
// Build with +define+BOOTH_CTRL_WDOG_EN to exercise the watchdog.
module tb_booth_ctrl;

   localparam int N = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic q0, qm1, eqz;
   logic ld_a, clr_a, sft_a, ld_q, sft_q, ld_m, clr_ff, addsub;
   logic ld_cnt, de_cnt, busy, done, err;

   // bench datapath
   logic [15:0] a_r = '0, q_r = '0, m_r = '0;
   logic        qm1_r = 1'b0;
   logic [4:0]  cnt_r = '0;
   logic [15:0] mplier = '0, mcand = '0;
   bit          force_eqz0 = 1'b0;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   booth_ctrl u_dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start),
      .q0_i     (q0),
      .qm1_i    (qm1),
      .eqz_i    (eqz),
      .ld_a_o   (ld_a),
      .clr_a_o  (clr_a),
      .sft_a_o  (sft_a),
      .ld_q_o   (ld_q),
      .sft_q_o  (sft_q),
      .ld_m_o   (ld_m),
      .clr_ff_o (clr_ff),
      .addsub_o (addsub),
      .ld_cnt_o (ld_cnt),
      .de_cnt_o (de_cnt),
      .busy_o   (busy),
      .done_o   (done),
      .err_o    (err)
   );

   assign q0  = q_r[0];
   assign qm1 = qm1_r;
   assign eqz = force_eqz0 ? 1'b0 : (cnt_r == 5'd0);

   // Behavioural datapath reacting to the controller strobes.
   always @(posedge clk) begin
      if (ld_m)   m_r   <= mcand;
      if (ld_q)   q_r   <= mplier;
      if (clr_a)  a_r   <= '0;
      if (clr_ff) qm1_r <= 1'b0;
      if (ld_cnt) cnt_r <= 5'(N);
      if (ld_a)   a_r   <= addsub ? (a_r + m_r) : (a_r - m_r);
      if (sft_a && sft_q) {a_r, q_r, qm1_r} <= {a_r[15], a_r, q_r};
      if (de_cnt) cnt_r <= cnt_r - 5'd1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [12:0] all_outs();
      return {ld_a, clr_a, sft_a, ld_q, sft_q, ld_m, clr_ff, addsub,
              ld_cnt, de_cnt, busy, done, err};
   endfunction

   // Request one multiply: start is high across exactly one rising edge.
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Walk negedges until done, counting strobes. cyc counts cycles since
   // the edge that sampled start (LOAD is cycle 1).
   task automatic wait_done(input int limit, output int cyc, output int lda,
                            output int dec, output int ldm, output int errs,
                            output int op0, output int op1, output bit timeout);
      cyc = 0; lda = 0; dec = 0; ldm = 0; errs = 0; op0 = -1; op1 = -1;
      timeout = 1'b1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         cyc++;
         if (ld_a) begin
            if (lda == 0) op0 = int'(addsub);
            if (lda == 1) op1 = int'(addsub);
            lda++;
         end
         if (de_cnt) dec++;
         if (ld_m)   ldm++;
         if (err)    errs++;
         if (done) begin
            timeout = 1'b0;
            break;
         end
      end
   endtask

   task automatic run_mult(input string tag, input logic [15:0] mp, input logic [15:0] mc,
                           input int exp_lat, input int exp_lda, input int exp_dec,
                           input logic [31:0] exp_prod, input int exp_err);
      int cyc, lda, dec, ldm, errs, op0, op1;
      bit to;
      mplier = mp;
      mcand  = mc;
      pulse_start();
      wait_done(80, cyc, lda, dec, ldm, errs, op0, op1, to);
      check({tag, "_timeout"}, 32'(to), 32'd0);
      check({tag, "_latency"}, cyc, exp_lat);
      check({tag, "_lda"},     lda, exp_lda);
      check({tag, "_decnt"},   dec, exp_dec);
      check({tag, "_err"},     errs, exp_err);
      @(negedge clk);
      check({tag, "_product"}, {a_r, q_r}, exp_prod);
      check({tag, "_done_w"},  {31'd0, done}, 32'd0);
      check({tag, "_idle"},    {31'd0, busy}, 32'd0);
      if (tag == "m0001") begin
         check({tag, "_op0_sub"}, op0, 0);
         check({tag, "_op1_add"}, op1, 1);
      end
   endtask

   initial begin : main
      int  cyc, lda, dec, ldm, errs, op0, op1, subs;
      bit  to;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outs", 32'(all_outs()), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_outs", 32'(all_outs()), 32'd0);

      // main function, hand-computed products
      run_mult("m0000", 16'h0000, 16'h1234, 35,  0, 16, 32'h0000_0000, 0);
      run_mult("m0001", 16'h0001, 16'h0007, 37,  2, 16, 32'h0000_0007, 0);
      run_mult("m5555", 16'h5555, 16'hFFFD, 51, 16, 16, 32'hFFFF_0001, 0);

      // start held high: back-to-back products, start ignored while busy
      mplier = 16'h0000;
      mcand  = 16'h0001;
      @(negedge clk);
      start = 1'b1;
      wait_done(80, cyc, lda, dec, ldm, errs, op0, op1, to);
      check("b2b_first_timeout", 32'(to), 32'd0);
      for (int k = 0; k < 2; k++) begin
         wait_done(80, cyc, lda, dec, ldm, errs, op0, op1, to);
         check("b2b_timeout", 32'(to), 32'd0);
         check("b2b_spacing", cyc, 36);
         check("b2b_loads",   ldm, 1);
      end
      @(negedge clk);
      check("b2b_done_w", {31'd0, done}, 32'd0);
      start = 1'b0;
      repeat (40) @(negedge clk);
      check("b2b_drained", {31'd0, busy}, 32'd0);

      // reset in SUB at iteration 7, then a clean run
      mplier = 16'h5555;
      mcand  = 16'h0003;
      pulse_start();
      subs = 0;
      to   = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (ld_a && !addsub) subs++;
         if (subs == 4) begin   // SUB happens on iterations 1,3,5,7
            to = 1'b0;
            break;
         end
      end
      check("rst_reach_sub7", 32'(to), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_outs", 32'(all_outs()), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_idle", 32'(all_outs()), 32'd0);
      run_mult("m0001", 16'h0001, 16'h0007, 37, 2, 16, 32'h0000_0007, 0);

      // counter never reaches zero
      force_eqz0 = 1'b1;
      mplier = 16'h0000;
`ifdef BOOTH_CTRL_WDOG_EN
      pulse_start();
      wait_done(80, cyc, lda, dec, ldm, errs, op0, op1, to);
      check("wdog_timeout", 32'(to), 32'd0);
      check("wdog_latency", cyc, 37);
      check("wdog_shifts",  dec, 17);
      check("wdog_err",     {31'd0, err}, 32'd1);
      @(negedge clk);
      check("wdog_err_w",   {31'd0, err}, 32'd0);
`else
      pulse_start();
      wait_done(60, cyc, lda, dec, ldm, errs, op0, op1, to);
      check("nowdog_no_done", 32'(to), 32'd1);
      check("nowdog_err",     errs, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("nowdog_rst_outs", 32'(all_outs()), 32'd0);
`endif
      force_eqz0 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
